// File: rtl/monopix_pkg.sv
// ============================================================================
//  monopix_pkg
//  Configuration word layout and the hard-wired safe default configuration.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package monopix_pkg;

    typedef struct packed {
        logic [3:0]   nEN_HITOR_OUT;
        logic [3:0]   SET_IBUFN_L;
        logic [3:0]   SET_IBUFP_L;
        logic [3:0]   SET_IBUFN_R;
        logic [3:0]   SET_IBUFP_R;
        logic [447:0] COL_PULSE_SEL;
    } t_conf;

    localparam int CONF_WIDTH = $bits(t_conf);

    // HitOr outputs disabled, mid-scale buffer bias, no column injection.
    localparam t_conf DEFAULT_CONF = '{
        nEN_HITOR_OUT: 4'hF,
        SET_IBUFN_L:   4'h8,
        SET_IBUFP_L:   4'h8,
        SET_IBUFN_R:   4'h8,
        SET_IBUFP_R:   4'h8,
        COL_PULSE_SEL: '0
    };

endpackage

`default_nettype wire

// File: rtl/monopix_if.sv
// ============================================================================
//  monopix_if
//  Configuration pad bundle: control pads in, serial readback and bus out.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface monopix_if;
    import monopix_pkg::*;

    logic  DEF_CONF_PAD;
    logic  LD_CONF_PAD;
    logic  SI_CONF_PAD;
    logic  SO_CONF_PAD;
    t_conf CONF_OUT;

    modport master (
        output DEF_CONF_PAD,
        output LD_CONF_PAD,
        output SI_CONF_PAD,
        input  SO_CONF_PAD,
        input  CONF_OUT
    );

    modport slave (
        input  DEF_CONF_PAD,
        input  LD_CONF_PAD,
        input  SI_CONF_PAD,
        output SO_CONF_PAD,
        output CONF_OUT
    );

endinterface

`default_nettype wire

// File: rtl/monopix_conf_sr.sv
// ============================================================================
//  conf_sr
//  Serial configuration shift register, MSB first; its MSB is the serial out.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module conf_sr
    import monopix_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  si,
    output logic                       so,
    output logic [CONF_WIDTH-1:0]      sr
);

    logic [CONF_WIDTH-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else begin
            r_sr <= {r_sr[CONF_WIDTH-2:0], si};
        end
    end

    assign sr = r_sr;
    assign so = r_sr[CONF_WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/monopix.sv
// ============================================================================
//  monopix
//  Configuration front end: shift register, transparent load latch, default mux.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module monopix
    import monopix_pkg::*;
(
    input  wire logic  CLK_CONF_PAD,
    input  wire logic  RESETB_PAD,
    monopix_if.slave   cfg
);

    logic [CONF_WIDTH-1:0] w_sr;
    t_conf                 r_conf_q;

    conf_sr u_conf_sr (
        .clk   (CLK_CONF_PAD),
        .rst_n (RESETB_PAD),
        .si    (cfg.SI_CONF_PAD),
        .so    (cfg.SO_CONF_PAD),
        .sr    (w_sr)
    );

    // Level-sensitive active latch; load is only raised while the shift clock
    // is stopped, so the transparent window never sees sr moving.
    always_latch begin
        if (!RESETB_PAD) begin
            r_conf_q <= '0;
        end else if (cfg.LD_CONF_PAD) begin
            r_conf_q <= t_conf'(w_sr);
        end
    end

    assign cfg.CONF_OUT = cfg.DEF_CONF_PAD ? DEFAULT_CONF : r_conf_q;

endmodule

`default_nettype wire

// File: tb/tb_monopix.sv
// Directed sequence with random words, checked against a bit-history model of
// the configuration front end.
`default_nettype none

module tb_monopix;
    import monopix_pkg::*;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;

    monopix_if bus ();

    monopix dut (
        .CLK_CONF_PAD (clk),
        .RESETB_PAD   (rst_n),
        .cfg          (bus.slave)
    );

    // Gated clock: once disabled it finishes its high phase and parks low.
    always #5 if (clk_en || clk) clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bit         hist[$];     // every bit shifted since the last reset
    bit         stim_q[$];   // bits to present, first element first
    logic [467:0] latched;   // model of the active latch
    logic [467:0] def_model;
    logic       def_flag;

    task automatic check(input string tag, input logic [467:0] obs, input logic [467:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Shift register contents = the last 468 bits shifted, earliest at the MSB.
    function automatic logic [467:0] model_sr();
        logic [467:0] r;
        int base;
        base = hist.size() - 468;
        for (int j = 0; j < 468; j++)
            r[467-j] = (base + j >= 0) ? hist[base + j] : 1'b0;
        return r;
    endfunction

    function automatic logic [467:0] model_out();
        return def_flag ? def_model : latched;
    endfunction

    function automatic logic model_so();
        int idx;
        idx = hist.size() - 468;
        return (idx >= 0) ? hist[idx] : 1'b0;
    endfunction

    task automatic set_def(input logic d);
        bus.DEF_CONF_PAD = d;
        def_flag = d;
        #1;
    endtask

    task automatic push_word(input logic [467:0] w);
        for (int i = 467; i >= 0; i--) stim_q.push_back(w[i]);
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back(bit'($urandom_range(0, 1)));
    endtask

    // Shift the queued bits; optionally pulse reset right after edge rst_at.
    task automatic shift_q(input int rst_at);
        int n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                bus.SI_CONF_PAD = stim_q[0];
                #1 clk_en = 1'b1;
            end else begin
                @(negedge clk);
                bus.SI_CONF_PAD = stim_q[i];
            end
            @(posedge clk);
            hist.push_back(stim_q[i]);
            if (i == n - 1) clk_en = 1'b0;
            #1;
            check_bit("so_stream", bus.SO_CONF_PAD, model_so());
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                hist.delete();
                latched = '0;
                check_bit("rst_mid_shift_so", bus.SO_CONF_PAD, 1'b0);
                check("rst_mid_shift_out", bus.CONF_OUT, model_out());
                rst_n = 1'b1;
            end
        end
        stim_q.delete();
        wait (clk == 1'b0);
        #7;
    endtask

    task automatic load_pulse();
        bus.LD_CONF_PAD = 1'b1;
        latched = model_sr();
        #1;
        check("load_transparent", bus.CONF_OUT, model_out());
        #10;
        bus.LD_CONF_PAD = 1'b0;
        #4;
    endtask

    initial begin
        logic [467:0] walk;
        logic [467:0] word_a;
        t_conf        tmp;

        tmp = '0;
        tmp.nEN_HITOR_OUT = 4'hF;
        tmp.SET_IBUFN_L   = 4'h8;
        tmp.SET_IBUFP_L   = 4'h8;
        tmp.SET_IBUFN_R   = 4'h8;
        tmp.SET_IBUFP_R   = 4'h8;
        def_model = tmp;
        latched   = '0;

        bus.LD_CONF_PAD = 1'b0;
        bus.SI_CONF_PAD = 1'b0;
        set_def(1'b1);

        // Reset state
        #5;
        check_bit("reset_so", bus.SO_CONF_PAD, 1'b0);
        check("reset_out_def", bus.CONF_OUT, model_out());
        set_def(1'b0);
        check("reset_out_zero", bus.CONF_OUT, 468'd0);
        #5 rst_n = 1'b1;
        #10;

        // Walking pattern under default override
        tmp = '0;
        tmp.COL_PULSE_SEL[447] = 1'b1;
        tmp.nEN_HITOR_OUT      = 4'b0101;
        tmp.SET_IBUFP_L        = 4'h5;
        walk = tmp;
        set_def(1'b1);
        push_word(walk);
        shift_q(-1);
        load_pulse();
        check("walk_def_held", bus.CONF_OUT, def_model);
        set_def(1'b0);
        check("walk_loaded", bus.CONF_OUT, walk);

        // Default override and release
        set_def(1'b1);
        check("override_on", bus.CONF_OUT, model_out());
        set_def(1'b0);
        check("override_off", bus.CONF_OUT, walk);

        // Readback: A emerges on SO while B goes in; no load keeps A
        for (int i = 0; i < 468; i++) word_a[i] = 1'($urandom_range(0, 1));
        push_word(word_a);
        shift_q(-1);
        load_pulse();
        check("word_a_loaded", bus.CONF_OUT, word_a);
        push_random(468);
        shift_q(-1);
        check("no_load_holds", bus.CONF_OUT, word_a);
        load_pulse();
        check("word_b_loaded", bus.CONF_OUT, model_out());

        // Overshift and undershift
        push_random(470);
        shift_q(-1);
        load_pulse();
        check("overshift", bus.CONF_OUT, model_out());
        push_random(100);
        shift_q(-1);
        load_pulse();
        check("undershift", bus.CONF_OUT, model_out());

        // Reset in the middle of a shift, then finish the word
        push_random(300);
        shift_q(137);
        check("post_rst_hold", bus.CONF_OUT, 468'd0);
        load_pulse();
        check("post_rst_load", bus.CONF_OUT, model_out());

        // Reset during the load pulse dominates
        bus.LD_CONF_PAD = 1'b1;
        latched = model_sr();
        #3;
        rst_n = 1'b0;
        #1;
        hist.delete();
        latched = '0;
        check("rst_in_load_out", bus.CONF_OUT, 468'd0);
        check_bit("rst_in_load_so", bus.SO_CONF_PAD, 1'b0);
        rst_n = 1'b1;
        #2;
        check("rst_released_load", bus.CONF_OUT, model_sr());
        bus.LD_CONF_PAD = 1'b0;
        #2;
        set_def(1'b1);
        check("final_def", bus.CONF_OUT, def_model);
        set_def(1'b0);
        check("final_zero", bus.CONF_OUT, 468'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
